// File: rtl/timer_pkg.sv
// Shared definitions for the Timer0/Timer1 down-counter peripheral:
// register offsets, CTRL bit positions, mode codes and FSM state encoding.
package timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_PSC_LO  = 8;
    localparam int CTRL_PSC_HI  = 15;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } timer_state_e;

    // Codes 10 and 11 fall back to one-shot behaviour.
    function automatic logic is_auto(input logic [1:0] mode);
        return mode == MODE_AUTO;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Bridge-to-timer word bus: the bridge drives address/strobe/data, the timer
// answers with combinational read data and its registered interrupt line.
interface timer_counter_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, WE, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_prescaler.sv
// Tick generator for the timer: one tick every psc+1 cycles, restartable
// through clear. Used only when TIMER_PRESCALE_EN is defined.
module timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic [7:0] psc,
    output logic       tick
);

    logic [7:0] cnt;

    // >= keeps the divider from running the long way round if psc shrinks mid-run.
    assign tick = (cnt >= psc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 8'd0;
        end else if (clear || tick) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/timer_counter.sv
// Timer0/Timer1 memory-mapped down-counter with one-shot / auto-reload IRQ.
// Define TIMER_PRESCALE_EN to enable the CTRL[15:8] prescaler.
module timer_counter
    import timer_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    timer_counter_if.slave bus
);

`ifdef TIMER_PRESCALE_EN
    localparam logic [31:0] CTRL_WMASK = 32'h0000_FF0F;
`else
    localparam logic [31:0] CTRL_WMASK = 32'h0000_000F;
`endif

    logic [31:0]  ctrl, preset, count;
    logic         irq_flag, irq_flag_nxt, im_nxt, irq_q;
    timer_state_e state, state_nxt;
    logic [1:0]   reg_sel;
    logic         wr_ctrl, wr_preset, stop_wr, tick;
    logic         load_cnt, dec_cnt, zero_cnt, set_flag, clr_flag, clr_en;
    logic         unused_addr;

    assign reg_sel     = bus.Addr[3:2];
    assign unused_addr = ^{bus.Addr[31:4], bus.Addr[1:0]};
    assign wr_ctrl     = bus.WE && (reg_sel == REG_CTRL);
    assign wr_preset   = bus.WE && (reg_sel == REG_PRESET);
    assign stop_wr     = wr_ctrl && !bus.Din[CTRL_EN];

`ifdef TIMER_PRESCALE_EN
    timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_LOAD),
        .psc   (ctrl[CTRL_PSC_HI:CTRL_PSC_LO]),
        .tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ctrl[CTRL_EN]) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_CNT;
            ST_CNT: begin
                if (!ctrl[CTRL_EN]) begin
                    state_nxt = ST_IDLE;
                end else if (tick && (count <= 32'd1)) begin
                    state_nxt = ST_INT;
                end
            end
            ST_INT:  state_nxt = is_auto(ctrl[CTRL_MODE_HI:CTRL_MODE_LO]) ? ST_LOAD : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (stop_wr) state_nxt = ST_IDLE;
    end

    // A stop write freezes the datapath at the same edge it parks the FSM.
    always_comb begin
        load_cnt = 1'b0;
        dec_cnt  = 1'b0;
        zero_cnt = 1'b0;
        set_flag = 1'b0;
        clr_flag = 1'b0;
        clr_en   = 1'b0;
        if (!stop_wr) begin
            case (state)
                ST_LOAD: load_cnt = 1'b1;
                ST_CNT: begin
                    if (ctrl[CTRL_EN] && tick) begin
                        if (count > 32'd1) begin
                            dec_cnt = 1'b1;
                        end else begin
                            zero_cnt = 1'b1;
                            set_flag = 1'b1;
                        end
                    end
                end
                ST_INT: begin
                    if (is_auto(ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) clr_flag = 1'b1;
                    else                                          clr_en   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // IRQ is registered from the post-edge flag and mask so it rises with INT
    // and a CTRL write can never leave a stale request behind.
    always_comb begin
        irq_flag_nxt = irq_flag;
        if (set_flag) irq_flag_nxt = 1'b1;
        if (clr_flag) irq_flag_nxt = 1'b0;
        if (wr_ctrl)  irq_flag_nxt = 1'b0;
        im_nxt = wr_ctrl ? bus.Din[CTRL_IM] : ctrl[CTRL_IM];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl     <= 32'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl <= bus.Din & CTRL_WMASK;
            end else if (clr_en) begin
                ctrl[CTRL_EN] <= 1'b0;
            end
            if (wr_preset) preset <= bus.Din;
            if (load_cnt) begin
                count <= preset;
            end else if (dec_cnt) begin
                count <= count - 32'd1;
            end else if (zero_cnt) begin
                count <= 32'd0;
            end
            irq_flag <= irq_flag_nxt;
            irq_q    <= irq_flag_nxt & im_nxt;
        end
    end

    always_comb begin
        bus.Dout = 32'd0;
        case (reg_sel)
            REG_CTRL:   bus.Dout = ctrl;
            REG_PRESET: bus.Dout = preset;
            REG_COUNT:  bus.Dout = count;
            default:    bus.Dout = 32'd0;
        endcase
    end

    assign bus.IRQ = irq_q;

endmodule
